mem_c_collect: RTL and testbench
================================

# mem_c_collect

Output-side collector for the systolic matrix-multiply datapath; the counterpart to the skewed A/B input feeders. While the array drains, the block receives one diagonal wavefront per cycle (column j lags column j-1 by one cycle), de-skews it into a DIM x DIM result buffer, and then serves whole rows of C to the host/readback logic by row address. It owns the drain sequencing: a beat counter, capture/full state, and a registered read port.

## Interface
- BITS_C, 24, signed width of one C element (accumulated product)
- DIM, 8, array dimension (rows = columns = DIM)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cap_en  in  1  drain beat valid: Cin holds this cycle's wavefront
- Cin  in  signed [BITS_C-1:0] x DIM  column outputs from array bottom edge
- rd_en  in  1  row read request
- Crow  in  $clog2(DIM)  row address for read
- Cout  out  signed [BITS_C-1:0] x DIM  registered row data
- rd_valid  out  1  Cout valid this cycle
- busy  out  1  drain in progress
- done  out  1  full matrix captured, buffer readable

## Operation
- Clock and reset are `clk` and `rst`; reset is synchronous and active-high.
- Storage: buf[r][c], DIM x DIM signed BITS_C registers. Beat counter k, width $clog2(2*DIM-1), range 0..2*DIM-2.
- States: IDLE, CAPTURE, FULL.
- Wavefront mapping: on accepted beat k, column c carries C[k-c][c]; write buf[k-c][c] <= Cin[c] only when 0 <= k-c <= DIM-1. Other columns are ignored for that beat.
- IDLE: cap_en=1 -> write beat 0, k<=1, go to CAPTURE.
- CAPTURE: cap_en=1 -> write beat k, k<=k+1. On the beat with k = 2*DIM-2 -> k<=0, go to FULL. cap_en=0 -> pause; k and buf hold, with no timeout. Drain beats need not be contiguous.
- FULL: done=1. cap_en=1 -> start a new drain as beat 0, go to CAPTURE, done<=0. Entries not yet rewritten keep their old values.
- Reads: accepted only in FULL with cap_en=0. Next cycle Cout <= buf[Crow], rd_valid=1.
  - In IDLE or CAPTURE, or in FULL with cap_en=1 (capture wins), the read is dropped: rd_valid=0 next cycle and Cout holds its last value.
- Crow >= DIM (non-power-of-2 DIM): read returns all zeros with rd_valid=1.
- busy = (state == CAPTURE). done = (state == FULL). Both are registered state decodes.
- Mid-operation reset: the drain is abandoned, buf cleared, state returns to IDLE.

## Timing
- Reset values: state IDLE, k=0, buf all 0, Cout all 0, rd_valid 0, busy 0, done 0.
- Write latency: an element sampled on the edge where cap_en=1 is visible in buf on that same edge.
- Full drain takes exactly 2*DIM-1 accepted beats (15 for DIM=8).
- done rises the cycle after the final beat's edge and stays high until the next accepted cap_en.
- A read issued in the first FULL cycle is legal and returns final data.
- Read latency: 1 cycle. rd_en at edge n gives Cout/rd_valid valid after edge n+1. rd_valid is a 1-cycle pulse per request; back-to-back reads give one row per cycle.
- No combinational path from any input to any output.

## Test plan
- Reset: assert rst 2 cycles mid-CAPTURE (k=5), then read after a fresh full drain -> after reset busy=0, done=0, rd_valid=0, Cout=0. Subsequent data correct.
- Nominal drain, DIM=8: C[i][j]=i*8+j, driven as skewed wavefronts for 15 contiguous beats -> busy high for beats 1..14, done rises after beat 14. Reads of rows 0..7 back-to-back return rows {8i..8i+7}, rd_valid high 8 consecutive cycles.
- Stalled drain: same matrix with cap_en low for 3 cycles after beats 3 and 10 -> identical buffer contents. done asserts only after the 15th accepted beat.
- Read gating: rd_en during CAPTURE, and rd_en together with cap_en in FULL -> rd_valid=0 and Cout unchanged in both cases. The second case also restarts the drain (done=0, busy=1).
- Signed extremes, BITS_C=24: C[0][7]=-8388608, C[7][0]=8388607, C[7][7]=-1 -> read back bit-exact, no sign corruption, neighbouring entries unaffected.
- Back-to-back matrices: second drain with C[i][j]=-(i*8+j) started in the first FULL cycle -> done low for 15 beats, then every row reads the negated values.

Source files
------------

// File: rtl/mem_c_collect_if.sv
// rtl/mem_c_collect_if.sv - drain/readback port bundle for the systolic C collector
//
// Signals:
//   cap_en    host -> collector  drain beat valid, Cin holds this beat's wavefront
//   Cin       host -> collector  DIM column outputs from the array bottom edge
//   rd_en     host -> collector  row read request
//   Crow      host -> collector  row address for the read
//   Cout      collector -> host  registered row data
//   rd_valid  collector -> host  Cout valid this cycle
//   busy      collector -> host  drain in progress
//   done      collector -> host  full matrix captured, buffer readable
interface mem_c_collect_if #(
  parameter int BITS_C = 24,
  parameter int DIM    = 8
);
  localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;

  logic                         cap_en;
  logic [DIM-1:0][BITS_C-1:0]   Cin;
  logic                         rd_en;
  logic [RW-1:0]                Crow;
  logic [DIM-1:0][BITS_C-1:0]   Cout;
  logic                         rd_valid;
  logic                         busy;
  logic                         done;

  modport master (
    output cap_en, Cin, rd_en, Crow,
    input  Cout, rd_valid, busy, done
  );

  modport slave (
    input  cap_en, Cin, rd_en, Crow,
    output Cout, rd_valid, busy, done
  );
endinterface

// File: rtl/mem_c_collect.sv
// rtl/mem_c_collect.sv - de-skews systolic drain wavefronts into a DIM x DIM buffer and serves rows
//
// Ports:
//   clk   clock, all state updates on the rising edge
//   rst   synchronous active-high reset
//   cif   mem_c_collect_if.slave: cap_en/Cin drain beats in, rd_en/Crow row reads in,
//         Cout/rd_valid registered read data out, busy/done registered status out
module mem_c_collect #(
  parameter int BITS_C = 24,
  parameter int DIM    = 8
) (
  input  logic           clk,
  input  logic           rst,
  mem_c_collect_if.slave cif
);
  localparam int KW = $clog2(2*DIM-1);
  localparam logic [KW-1:0] KLAST = KW'(2*DIM-2);

  typedef enum logic [1:0] {IDLE, CAPTURE, FULL} state_t;

  state_t                     state;
  logic [KW-1:0]              k;
  logic [BITS_C-1:0]          cbuf [DIM][DIM];
  logic [DIM-1:0][BITS_C-1:0] rd_row;
  logic [DIM-1:0][BITS_C-1:0] cout_q;
  logic                       rd_valid_q;
  logic                       busy_q;
  logic                       done_q;

  // Outside CAPTURE an accepted beat always starts a fresh drain at beat 0.
  logic [KW-1:0] beat;
  assign beat = (state == CAPTURE) ? k : '0;

  // Capture has priority over readback in FULL.
  logic rd_ok;
  assign rd_ok = cif.rd_en && (state == FULL) && !cif.cap_en;

  // Out-of-range rows (only possible for non-power-of-2 DIM) read as zero.
  logic row_in;
  assign row_in = (int'(cif.Crow) < DIM);

  // Beat k carries C[k-c][c] on column c, so cell (r,c) is written on beat r+c.
  for (genvar r = 0; r < DIM; r++) begin : g_row
    for (genvar c = 0; c < DIM; c++) begin : g_col
      always_ff @(posedge clk) begin
        if (rst) begin
          cbuf[r][c] <= '0;
        end else if (cif.cap_en && (beat == KW'(r + c))) begin
          cbuf[r][c] <= cif.Cin[c];
        end
      end
    end
  end

  for (genvar c = 0; c < DIM; c++) begin : g_rd
    assign rd_row[c] = row_in ? cbuf[cif.Crow][c] : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      cout_q     <= '0;
    end else begin
      rd_valid_q <= rd_ok;
      if (rd_ok) begin
        cout_q <= rd_row;
      end
      if (cif.cap_en) begin
        if (beat == KLAST) begin
          state  <= FULL;
          k      <= '0;
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          state  <= CAPTURE;
          k      <= beat + 1'b1;
          busy_q <= 1'b1;
          done_q <= 1'b0;
        end
      end
    end
  end

  assign cif.Cout     = cout_q;
  assign cif.rd_valid = rd_valid_q;
  assign cif.busy     = busy_q;
  assign cif.done     = done_q;
endmodule

// File: tb/tb_mem_c_collect.sv
// tb/tb_mem_c_collect.sv - scoreboard bench for mem_c_collect
module tb_mem_c_collect;
  localparam int BITS_C = 24;
  localparam int DIM    = 8;

  typedef logic [DIM-1:0][BITS_C-1:0] row_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_c_collect_if #(.BITS_C(BITS_C), .DIM(DIM)) cif ();

  mem_c_collect #(.BITS_C(BITS_C), .DIM(DIM)) dut (
    .clk (clk),
    .rst (rst),
    .cif (cif)
  );

  int checks = 0;
  int errors = 0;
  row_t q[$];
  logic [BITS_C-1:0] exp_m [DIM][DIM];

  task automatic chk(input string name, input row_t act, input row_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", name, act, exp);
    end
  endtask

  // mode 0: i*8+j, mode 1: -(i*8+j), mode 2: mode 0 with signed extremes planted
  function automatic logic [BITS_C-1:0] val(input int mode, input int i, input int j);
    int v;
    v = i * DIM + j;
    if (mode == 1) v = -v;
    if (mode == 2) begin
      if (i == 0 && j == 7) v = -8388608;
      if (i == 7 && j == 0) v = 8388607;
      if (i == 7 && j == 7) v = -1;
    end
    return v[BITS_C-1:0];
  endfunction

  function automatic row_t exp_row(input int r);
    row_t t;
    for (int c = 0; c < DIM; c++) t[c] = exp_m[r][c];
    return t;
  endfunction

  // Monitor: every rd_valid must match the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (cif.rd_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rd_valid got 1 want 0");
      end else begin
        chk("row", cif.Cout, q.pop_front());
      end
    end
  end

  task automatic drain(input int mode, input int stall_a, input int stall_b,
                       input int nbeats, input bit rd_first, input bit rd_stall);
    row_t held;
    held = cif.Cout;
    for (int b = 0; b < nbeats; b++) begin
      cif.cap_en = 1'b1;
      for (int c = 0; c < DIM; c++) begin
        if (b - c >= 0 && b - c < DIM) cif.Cin[c] = val(mode, b - c, c);
        else cif.Cin[c] = BITS_C'(32'h5A5A00 + c);
      end
      cif.rd_en = rd_first && (b == 0);
      cif.Crow  = 3'd3;
      @(negedge clk);
      cif.rd_en = 1'b0;
      if (b == 2*DIM-2) begin
        chk1("busy_after_last", cif.busy, 1'b0);
        chk1("done_after_last", cif.done, 1'b1);
      end else begin
        chk1("busy_beat", cif.busy, 1'b1);
        chk1("done_beat", cif.done, 1'b0);
      end
      if (rd_first && b == 0) begin
        chk1("rd_drop_full_cap", cif.rd_valid, 1'b0);
        chk("cout_hold_full_cap", cif.Cout, held);
      end
      if (b == stall_a || b == stall_b) begin
        repeat (3) begin
          cif.cap_en = 1'b0;
          cif.rd_en  = rd_stall;
          cif.Crow   = 3'd2;
          @(negedge clk);
          cif.rd_en = 1'b0;
          chk1("busy_stall", cif.busy, 1'b1);
          chk1("done_stall", cif.done, 1'b0);
          if (rd_stall) begin
            chk1("rd_drop_capture", cif.rd_valid, 1'b0);
            chk("cout_hold_capture", cif.Cout, held);
          end
        end
      end
    end
    cif.cap_en = 1'b0;
    if (nbeats == 2*DIM-1) begin
      for (int i = 0; i < DIM; i++)
        for (int j = 0; j < DIM; j++) exp_m[i][j] = val(mode, i, j);
    end
  endtask

  task automatic read_all();
    for (int r = 0; r < DIM; r++) begin
      cif.rd_en = 1'b1;
      cif.Crow  = 3'(r);
      q.push_back(exp_row(r));
      @(negedge clk);
    end
    cif.rd_en = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk1({tag, "_busy"}, cif.busy, 1'b0);
    chk1({tag, "_done"}, cif.done, 1'b0);
    chk1({tag, "_rd_valid"}, cif.rd_valid, 1'b0);
    chk({tag, "_cout"}, cif.Cout, '0);
  endtask

  initial begin
    cif.cap_en = 1'b0;
    cif.Cin    = '0;
    cif.rd_en  = 1'b0;
    cif.Crow   = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_state("reset");

    // Nominal drain, then a negated matrix started in the first FULL cycle
    // with a simultaneous read that capture must win.
    drain(0, -1, -1, 2*DIM-1, 1'b0, 1'b0);
    drain(1, -1, -1, 2*DIM-1, 1'b1, 1'b0);
    read_all();

    // Stalled drain with reads attempted during the stalls.
    drain(0, 3, 10, 2*DIM-1, 1'b0, 1'b1);
    read_all();

    // Reset mid-capture at k=5, then a read in IDLE, then signed extremes.
    drain(0, -1, -1, 5, 1'b0, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_reset_state("midreset");
    cif.rd_en = 1'b1;
    cif.Crow  = 3'd1;
    @(negedge clk);
    cif.rd_en = 1'b0;
    chk1("rd_drop_idle", cif.rd_valid, 1'b0);
    chk("cout_hold_idle", cif.Cout, '0);
    drain(2, -1, -1, 2*DIM-1, 1'b0, 1'b0);
    read_all();

    repeat (3) @(negedge clk);
    chk1("queue_empty", q.size() == 0, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
